// File: rtl/wdt_pkg.sv
// Shared definitions for the windowed watchdog: register map, bit positions,
// default key values and FSM encoding.
package wdt_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] REG_CTRL   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd1;
  localparam logic [ADDR_W-1:0] REG_RELOAD = 3'd2;
  localparam logic [ADDR_W-1:0] REG_WINDOW = 3'd3;
  localparam logic [ADDR_W-1:0] REG_KEY    = 3'd4;
  localparam logic [ADDR_W-1:0] REG_COUNT  = 3'd5;

  localparam int unsigned CTRL_WEN     = 0;
  localparam int unsigned CTRL_RSTEN   = 1;
  localparam int unsigned CTRL_IEN     = 2;
  localparam int unsigned CTRL_WINEN   = 3;
  localparam int unsigned CTRL_PSEL_LO = 4;
  localparam int unsigned CTRL_LOCK    = 8;

  localparam int unsigned STAT_WDTIF  = 0;
  localparam int unsigned STAT_RSTF   = 1;
  localparam int unsigned STAT_EARLYF = 2;

  localparam logic [DATA_W-1:0] KEY_KICK_DEF = 16'hA5A5;
  localparam logic [DATA_W-1:0] KEY_STOP_DEF = 16'hDEAD;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running prescaler with a runtime-selectable tap; tick_c fires when the
// low PSEL+1 bits are all ones (PSEL clamped to PSC_W-1).
module wdt_prescaler #(
  parameter int unsigned PSC_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic [3:0] psel,
  output logic       tick_c
);

  logic [PSC_W-1:0] psc_q;
  logic [PSC_W-1:0] mask;
  logic [3:0]       tap;

  always_comb begin
    tap = ({1'b0, psel} > 5'(PSC_W - 1)) ? 4'(PSC_W - 1) : psel;
    for (int i = 0; i < PSC_W; i++) begin
      mask[i] = (4'(i) <= tap);
    end
  end

  assign tick_c = run && ((psc_q & mask) == mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
    end else if (clr) begin
      psc_q <= '0;
    end else if (run) begin
      psc_q <= psc_q + PSC_W'(1);
    end
  end

endmodule

// File: rtl/wdt_win.sv
// Windowed watchdog on the 16-bit peripheral bus. Optional CTRL lock bit is
// enabled by defining WDT_WIN_LOCK_EN.
module wdt_win
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned PSC_W     = 16,
  parameter int unsigned RST_PULSE = 4,
  parameter logic [15:0] KEY_KICK  = KEY_KICK_DEF,
  parameter logic [15:0] KEY_STOP  = KEY_STOP_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [2:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdy,
  output logic        o_int_req,
  output logic        o_rst_req
);

  state_t           state_q, state_d;
  logic             rsten_q, rsten_d, ien_q, ien_d, winen_q, winen_d;
  logic [3:0]       psel_q, psel_d;
  logic [2:0]       status_q, status_d, set, w1c;
  logic [CNT_W-1:0] reload_q, reload_d, window_q, window_d, cnt_q, cnt_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic             int_q, int_d, rst_q, rst_d;
  logic             tick_c, psc_clr, locked, wr, ctrl_wr, key_wr, fault;
  logic [15:0]      ctrl_rd;

`ifdef WDT_WIN_LOCK_EN
  logic lock_q, lock_d;
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  assign wr      = i_sel && i_we;
  assign ctrl_wr = wr && (i_addr == REG_CTRL) && !locked;
  assign key_wr  = wr && (i_addr == REG_KEY);

  wdt_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk    (i_clk),
    .rst    (i_rst),
    .run    (state_q == ST_RUN),
    .clr    (psc_clr),
    .psel   (psel_q),
    .tick_c (tick_c)
  );

  // Next-state: FSM, counter, kick/timeout arbitration, status and pulse.
  always_comb begin
    state_d  = state_q;
    rsten_d  = rsten_q;
    ien_d    = ien_q;
    winen_d  = winen_q;
    psel_d   = psel_q;
    reload_d = reload_q;
    window_d = window_q;
    cnt_d    = cnt_q;
    pcnt_d   = (pcnt_q != 4'd0) ? pcnt_q - 4'd1 : 4'd0;
    psc_clr  = 1'b0;
    fault    = 1'b0;
    set      = '0;
    w1c      = '0;
`ifdef WDT_WIN_LOCK_EN
    lock_d   = lock_q;
`endif

    if (ctrl_wr) begin
      rsten_d = i_wdata[CTRL_RSTEN];
      ien_d   = i_wdata[CTRL_IEN];
      winen_d = i_wdata[CTRL_WINEN];
      psel_d  = i_wdata[CTRL_PSEL_LO +: 4];
`ifdef WDT_WIN_LOCK_EN
      lock_d  = lock_q | i_wdata[CTRL_LOCK];
`endif
    end
    if (wr && (i_addr == REG_RELOAD) && !locked) reload_d = i_wdata[CNT_W-1:0];
    if (wr && (i_addr == REG_WINDOW) && !locked) window_d = i_wdata[CNT_W-1:0];
    if (wr && (i_addr == REG_STATUS)) w1c = i_wdata[2:0];

    case (state_q)
      ST_OFF: begin
        if (ctrl_wr && i_wdata[CTRL_WEN]) begin
          state_d = ST_RUN;
          cnt_d   = reload_q;
          psc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if ((ctrl_wr && !i_wdata[CTRL_WEN]) ||
            (key_wr && (i_wdata == KEY_STOP) && !locked)) begin
          state_d = ST_OFF;
        end
        // A kick is judged on the pre-tick count and overrides a coincident timeout.
        if (key_wr && (i_wdata == KEY_KICK)) begin
          cnt_d   = reload_q;
          psc_clr = 1'b1;
          if (winen_q && (cnt_q > window_q)) begin
            set[STAT_EARLYF] = 1'b1;
            set[STAT_WDTIF]  = 1'b1;
            fault            = 1'b1;
          end
        end else if (tick_c) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d           = reload_q;
            psc_clr         = 1'b1;
            set[STAT_WDTIF] = 1'b1;
            fault           = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (fault && rsten_q) begin
      set[STAT_RSTF] = 1'b1;
      pcnt_d         = 4'(RST_PULSE);
    end
    status_d = (status_q & ~w1c) | set;
    int_d    = (status_d[STAT_WDTIF] | status_d[STAT_EARLYF]) && ien_d;
    rst_d    = (pcnt_d != 4'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_OFF;
      rsten_q  <= 1'b0;
      ien_q    <= 1'b0;
      winen_q  <= 1'b0;
      psel_q   <= '0;
      status_q <= '0;
      reload_q <= '1;
      window_q <= '1;
      cnt_q    <= '1;
      pcnt_q   <= '0;
      int_q    <= 1'b0;
      rst_q    <= 1'b0;
`ifdef WDT_WIN_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rsten_q  <= rsten_d;
      ien_q    <= ien_d;
      winen_q  <= winen_d;
      psel_q   <= psel_d;
      status_q <= status_d;
      reload_q <= reload_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      int_q    <= int_d;
      rst_q    <= rst_d;
`ifdef WDT_WIN_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  // Zero-wait read mux.
  always_comb begin
    ctrl_rd                         = '0;
    ctrl_rd[CTRL_WEN]               = (state_q == ST_RUN);
    ctrl_rd[CTRL_RSTEN]             = rsten_q;
    ctrl_rd[CTRL_IEN]               = ien_q;
    ctrl_rd[CTRL_WINEN]             = winen_q;
    ctrl_rd[CTRL_PSEL_LO +: 4]      = psel_q;
`ifdef WDT_WIN_LOCK_EN
    ctrl_rd[CTRL_LOCK]              = lock_q;
`endif
    o_rdata = '0;
    if (i_sel && i_re) begin
      case (i_addr)
        REG_CTRL:   o_rdata = ctrl_rd;
        REG_STATUS: o_rdata = 16'(status_q);
        REG_RELOAD: o_rdata = 16'(reload_q);
        REG_WINDOW: o_rdata = 16'(window_q);
        REG_COUNT:  o_rdata = 16'(cnt_q);
        default:    o_rdata = '0;
      endcase
    end
  end

  assign o_rdy     = i_sel;
  assign o_int_req = int_q;
  assign o_rst_req = rst_q;

endmodule

// File: tb/tb_wdt_win.sv
// Directed bench for wdt_win: reset state, timeout, window kicks, stop/freeze,
// reset mid-pulse and the optional WDT_WIN_LOCK_EN lock.
module tb_wdt_win;
  import wdt_pkg::*;

  logic        i_clk, i_rst, i_sel, i_we, i_re;
  logic [2:0]  i_addr;
  logic [15:0] i_wdata, o_rdata;
  logic        o_rdy, o_int_req, o_rst_req;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] rd;
  logic        found;

  wdt_win dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_sel), .i_we(i_we), .i_re(i_re),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy),
    .o_int_req(o_int_req), .o_rst_req(o_rst_req)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    @(posedge i_clk);
    #1;
    i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    i_sel = 1'b1; i_re = 1'b1; i_addr = a;
    #1;
    d = o_rdata;
    i_sel = 1'b0; i_re = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_rd(a, v);
    chk(tag, 32'(v), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Poll COUNT once per cycle until it equals v, giving up after max_cyc cycles.
  task automatic wait_count(input logic [15:0] v, input int max_cyc, output logic ok);
    logic [15:0] c;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      bus_rd(REG_COUNT, c);
      if (c == v) ok = 1'b1;
      else begin
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    i_rst = 1'b1; i_sel = 1'b0; i_we = 1'b0; i_re = 1'b0; i_addr = '0; i_wdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset state
    chk_reg("rst_ctrl",   REG_CTRL,   16'h0000);
    chk_reg("rst_status", REG_STATUS, 16'h0000);
    chk_reg("rst_reload", REG_RELOAD, 16'hFFFF);
    chk_reg("rst_window", REG_WINDOW, 16'hFFFF);
    chk_reg("rst_count",  REG_COUNT,  16'hFFFF);
    chk_reg("rst_key_rd", REG_KEY,    16'h0000);
    chk_reg("rst_addr6",  3'd6,       16'h0000);
    chk("rst_int", 32'(o_int_req), 32'd0);
    chk("rst_rreq", 32'(o_rst_req), 32'd0);
    i_sel = 1'b1; i_addr = REG_RELOAD;
    #1;
    chk("rdy_sel", 32'(o_rdy), 32'd1);
    chk("rdata_no_re", 32'(o_rdata), 32'd0);
    i_sel = 1'b0;
    #1;
    chk("rdy_nosel", 32'(o_rdy), 32'd0);

    // 1: timeout with reset request
    bus_wr(REG_RELOAD, 16'd3);
    bus_wr(REG_CTRL, 16'h0003);
    repeat (5) @(posedge i_clk);
    #1;
    chk_reg("t1_cnt_before", REG_COUNT, 16'd1);
    chk_reg("t1_stat_before", REG_STATUS, 16'h0000);
    @(posedge i_clk);
    #1;
    chk_reg("t1_stat_to", REG_STATUS, 16'h0003);
    chk_reg("t1_cnt_reload", REG_COUNT, 16'd3);
    chk("t1_rreq_0", 32'(o_rst_req), 32'd1);
    chk("t1_int_off", 32'(o_int_req), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge i_clk);
      #1;
      chk($sformatf("t1_rreq_%0d", k), 32'(o_rst_req), 32'd1);
    end
    @(posedge i_clk);
    #1;
    chk("t1_rreq_end", 32'(o_rst_req), 32'd0);

    // 2: early kick inside window mode
    do_reset();
    bus_wr(REG_RELOAD, 16'd10);
    bus_wr(REG_WINDOW, 16'd4);
    bus_wr(REG_CTRL, 16'h000D);
    wait_count(16'd8, 40, found);
    chk("t2_reach8", 32'(found), 32'd1);
    bus_wr(REG_KEY, KEY_KICK_DEF);
    chk_reg("t2_stat_early", REG_STATUS, 16'h0005);
    chk_reg("t2_cnt_reload", REG_COUNT, 16'd10);
    chk("t2_int", 32'(o_int_req), 32'd1);
    chk("t2_rreq", 32'(o_rst_req), 32'd0);
    bus_wr(REG_STATUS, 16'h0005);
    chk_reg("t2_stat_w1c", REG_STATUS, 16'h0000);
    chk("t2_int_clr", 32'(o_int_req), 32'd0);

    // 3: valid kick in window, bogus key ignored
    wait_count(16'd3, 40, found);
    chk("t3_reach3", 32'(found), 32'd1);
    bus_wr(REG_KEY, KEY_KICK_DEF);
    chk_reg("t3_cnt_kick", REG_COUNT, 16'd10);
    chk_reg("t3_stat", REG_STATUS, 16'h0000);
    bus_wr(REG_KEY, 16'h1234);
    @(posedge i_clk);
    #1;
    chk_reg("t3_bogus_key", REG_COUNT, 16'd9);
    chk_reg("t3_stat_bogus", REG_STATUS, 16'h0000);

    // 4: kick coincident with timeout tick, then KEY_STOP freeze
    do_reset();
    bus_wr(REG_RELOAD, 16'd3);
    bus_wr(REG_CTRL, 16'h0001);
    repeat (5) @(posedge i_clk);
    bus_wr(REG_KEY, KEY_KICK_DEF);
    chk_reg("t4_cnt_kick_to", REG_COUNT, 16'd3);
    chk_reg("t4_stat_no_to", REG_STATUS, 16'h0000);
    bus_wr(REG_KEY, KEY_STOP_DEF);
    chk_reg("t4_ctrl_stop", REG_CTRL, 16'h0000);
    repeat (100) @(posedge i_clk);
    #1;
    chk_reg("t4_cnt_frozen", REG_COUNT, 16'd3);
    chk_reg("t4_stat_frozen", REG_STATUS, 16'h0000);

    // 5: synchronous reset in the middle of a reset-request pulse
    do_reset();
    bus_wr(REG_RELOAD, 16'd3);
    bus_wr(REG_CTRL, 16'h0003);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge i_clk);
      #1;
      found = o_rst_req;
    end
    chk("t5_pulse_seen", 32'(found), 32'd1);
    @(posedge i_clk);
    #1;
    chk("t5_mid_pulse", 32'(o_rst_req), 32'd1);
    do_reset();
    chk("t5_rreq_drop", 32'(o_rst_req), 32'd0);
    chk_reg("t5_ctrl", REG_CTRL, 16'h0000);
    chk_reg("t5_count", REG_COUNT, 16'hFFFF);
    chk_reg("t5_reload", REG_RELOAD, 16'hFFFF);
    chk_reg("t5_status", REG_STATUS, 16'h0000);

    // 6: CTRL lock bit
    do_reset();
    bus_wr(REG_CTRL, 16'h0103);
`ifdef WDT_WIN_LOCK_EN
    bus_wr(REG_CTRL, 16'h0000);
    bus_wr(REG_KEY, KEY_STOP_DEF);
    chk_reg("t6_lock_ctrl", REG_CTRL, 16'h0103);
    bus_wr(REG_RELOAD, 16'd5);
    chk_reg("t6_lock_reload", REG_RELOAD, 16'hFFFF);
`else
    chk_reg("t6_nolock_ctrl", REG_CTRL, 16'h0003);
    bus_wr(REG_CTRL, 16'h0000);
    chk_reg("t6_nolock_clr", REG_CTRL, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
